// File: rtl/mux_nto1_seq_if.sv
// Bus bundle for mux_nto1_seq: packed channel inputs, request controls and
// the valid/ready output beat with its side-band (channel, error, last, done).
interface mux_nto1_seq_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 16,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH*WIDTH-1:0] din;
  logic [SELW-1:0]      sel;
  logic                 mode;
  logic                 start;
  logic                 busy;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_err;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;
  logic                 done;

  // Requester / consumer side.
  modport master (
    output din, sel, mode, start, out_ready,
    input  busy, out_data, out_ch, out_err, out_last, out_valid, done
  );

  // Multiplexer side.
  modport slave (
    input  din, sel, mode, start, out_ready,
    output busy, out_data, out_ch, out_err, out_last, out_valid, done
  );
endinterface

// File: rtl/mux_nto1_seq.sv
// Registered N:1 multiplexer with a single-entry valid/ready output register
// and a channel sequencer: manual mode captures one selected channel per
// request, scan mode emits one beat per channel in order 0..NCH-1.
module mux_nto1_seq #(
  parameter int WIDTH = 8,
  parameter int NCH   = 16,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_nto1_seq_if.slave bus
);

  // Channel table padded to a power of two so any SELW-bit index is legal;
  // padding slots read as zero, which is also the forced data for a bad sel.
  localparam int                NSLOT   = 1 << SELW;
  localparam logic [SELW:0]     NCH_W   = (SELW + 1)'(NCH);
  localparam logic [SELW-1:0]   LAST_CH = SELW'(NCH - 1);
  localparam logic [SELW-1:0]   ONE_PTR = SELW'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [WIDTH-1:0] ch_data [NSLOT];

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    if (gi < NCH) begin : g_live
      assign ch_data[gi] = bus.din[gi*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch_data[gi] = '0;
    end
  end

  logic [0:0]       state_q, state_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_err_q, out_err_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;

  logic load_ok;
  logic busy;
  logic sel_err;

  // The output register may be refilled when empty or drained this cycle.
  assign load_ok = ~out_valid_q | bus.out_ready;
  assign busy    = (state_q == ST_SCAN) | (out_valid_q & ~bus.out_ready);
  assign sel_err = ({1'b0, bus.sel} >= NCH_W);

  // Next-state: sequencer control and output register loading.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    done_d      = out_valid_q & bus.out_ready & out_last_q;

    // A beat accepted with nothing new behind it empties the register.
    if (load_ok) begin
      out_valid_d = 1'b0;
    end

    if (state_q == ST_SCAN) begin
      if (load_ok) begin
        out_data_d  = ch_data[ptr_q];
        out_ch_d    = ptr_q;
        out_err_d   = 1'b0;
        out_last_d  = (ptr_q == LAST_CH);
        out_valid_d = 1'b1;
        if (ptr_q == LAST_CH) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ONE_PTR;
        end
      end
    end else if (bus.start && !busy) begin
      out_valid_d = 1'b1;
      if (!bus.mode) begin
        // Manual capture; an out-of-range select still yields a flagged beat.
        out_data_d = sel_err ? '0 : ch_data[bus.sel];
        out_ch_d   = bus.sel;
        out_err_d  = sel_err;
        out_last_d = 1'b1;
      end else begin
        out_data_d = ch_data[0];
        out_ch_d   = '0;
        out_err_d  = 1'b0;
        out_last_d = (NCH == 1);
        if (NCH > 1) begin
          ptr_d   = ONE_PTR;
          state_d = ST_SCAN;
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mux_nto1_seq.sv
// Scoreboard bench for mux_nto1_seq: a 16-channel and a 10-channel instance
// share the same stimulus; a transaction-level model pushes expected beats,
// a negedge monitor pops and compares them as the DUTs hand beats over.
module tb_mux_nto1_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   sel;
  logic         mode, start, out_ready;
  logic [127:0] din;
  logic [127:0] pat;

  mux_nto1_seq_if #(.WIDTH(8), .NCH(16)) if16 ();
  mux_nto1_seq_if #(.WIDTH(8), .NCH(10)) if10 ();

  assign if16.din = din;        assign if10.din = din[79:0];
  assign if16.sel = sel;        assign if10.sel = sel;
  assign if16.mode = mode;      assign if10.mode = mode;
  assign if16.start = start;    assign if10.start = start;
  assign if16.out_ready = out_ready;
  assign if10.out_ready = out_ready;

  mux_nto1_seq #(.WIDTH(8), .NCH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  mux_nto1_seq #(.WIDTH(8), .NCH(10)) u10 (.clk(clk), .rst_n(rst_n), .bus(if10.slave));

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] ch;
    logic       err;
    logic       last;
  } beat_t;

  beat_t q16[$];
  beat_t q10[$];

  int n_cmp = 0;
  int n_bad = 0;
  int nch_of [2] = '{16, 10};

  // Transaction model: is a beat held, which channels of a scan remain.
  bit hold [2], hold_last [2], scan_on [2], done_m [2], known [2], was_rst [2];
  int nxt [2];
  // Expectations describing the DUT just after the most recent clock edge.
  bit cur_valid [2], cur_busy [2], cur_done [2], cur_known [2], cur_rst [2];

  function void chk(string name, int idx, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s nch=%0d t=%0t: got %0d expected %0d", name, nch_of[idx], $time, act, exp);
    end
  endfunction

  function void push_beat(int idx, beat_t b);
    if (idx == 0) q16.push_back(b); else q10.push_back(b);
  endfunction

  function void drop_held(int idx);
    if (idx == 0) begin if (q16.size() > 0) void'(q16.pop_back()); end
    else begin if (q10.size() > 0) void'(q10.pop_back()); end
  endfunction

  // Advance the model across the coming edge using the inputs now applied.
  task automatic step(input int idx);
    int    n;
    bit    ld_ok, bsy;
    beat_t b;
    n = nch_of[idx];
    bsy = scan_on[idx] | (hold[idx] & !out_ready);
    cur_valid[idx] = hold[idx];
    cur_busy[idx]  = bsy;
    cur_done[idx]  = done_m[idx];
    cur_known[idx] = known[idx];
    cur_rst[idx]   = was_rst[idx];
    if (!rst_n) begin
      if (hold[idx] && !out_ready) drop_held(idx);
      hold[idx] = 0; scan_on[idx] = 0; nxt[idx] = 0;
      done_m[idx] = 0; known[idx] = 1; was_rst[idx] = 1;
      return;
    end
    was_rst[idx] = 0;
    done_m[idx] = hold[idx] & out_ready & hold_last[idx];
    ld_ok = !hold[idx] | out_ready;
    if (scan_on[idx] && ld_ok) begin
      b.data = din[nxt[idx]*8 +: 8];
      b.ch   = 4'(nxt[idx]);
      b.err  = 1'b0;
      b.last = (nxt[idx] == n - 1);
      push_beat(idx, b);
      hold[idx] = 1; hold_last[idx] = b.last;
      if (b.last) scan_on[idx] = 0; else nxt[idx]++;
    end else if (!scan_on[idx] && start && !bsy) begin
      if (!mode) begin
        b.err  = (int'(sel) >= n);
        b.data = b.err ? 8'h00 : din[int'(sel)*8 +: 8];
        b.ch   = sel;
        b.last = 1'b1;
      end else begin
        b.data = din[7:0];
        b.ch   = 4'd0;
        b.err  = 1'b0;
        b.last = (n == 1);
        if (n > 1) begin scan_on[idx] = 1; nxt[idx] = 1; end
      end
      push_beat(idx, b);
      hold[idx] = 1; hold_last[idx] = b.last;
    end else if (ld_ok) begin
      hold[idx] = 0;
    end
  endtask

  // Monitor comparison for one instance, run at the falling edge.
  task automatic check(input int idx, input logic valid, input logic busy,
                       input logic done, input logic [7:0] data,
                       input logic [3:0] ch, input logic err, input logic last);
    beat_t e;
    if (!cur_known[idx]) return;
    chk("valid", idx, int'(valid), int'(cur_valid[idx]));
    chk("busy",  idx, int'(busy),  int'(cur_busy[idx]));
    chk("done",  idx, int'(done),  int'(cur_done[idx]));
    if (cur_rst[idx]) chk("rst_zero", idx, int'({data, ch, err, last}), 0);
    if (valid === 1'b1 && out_ready) begin
      if ((idx == 0 ? q16.size() : q10.size()) == 0) begin
        chk("beat_unexpected", idx, 1, 0);
      end else begin
        e = (idx == 0) ? q16.pop_front() : q10.pop_front();
        chk("data", idx, int'(data), int'(e.data));
        chk("ch",   idx, int'(ch),   int'(e.ch));
        chk("err",  idx, int'(err),  int'(e.err));
        chk("last", idx, int'(last), int'(e.last));
        $display("beat nch=%0d ch=%0d data=%02h err=%0d last=%0d", nch_of[idx], ch, data, err, last);
      end
    end
  endtask

  always @(negedge clk) begin
    check(0, if16.out_valid, if16.busy, if16.done, if16.out_data, if16.out_ch, if16.out_err, if16.out_last);
    check(1, if10.out_valid, if10.busy, if10.done, if10.out_data, if10.out_ch, if10.out_err, if10.out_last);
  end

  // One clock of stimulus: apply inputs, update the model, cross the edge.
  task automatic cyc(input bit r, input bit s, input bit m, input int sl,
                     input bit rdy, input bit rnd);
    rst_n = r; start = s; mode = m; sel = 4'(sl); out_ready = rdy;
    din = rnd ? {$urandom, $urandom, $urandom, $urandom} : pat;
    step(0);
    step(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) pat[k*8 +: 8] = 8'hA0 + 8'(k);
    #1;
    // Reset held with start asserted and no ready, then idle.
    cyc(0, 1, 0, 5, 0, 0);
    cyc(0, 1, 0, 5, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 0);
    // Manual capture of channel 5.
    cyc(1, 1, 0, 5, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 0);
    // Scan at full rate with stray start pulses.
    cyc(1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 19; i++) cyc(1, 1'($urandom % 2), 1, 3, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, 0);
    // Scan under 1,0,0 backpressure with changing inputs.
    cyc(1, 1, 1, 0, 1, 1);
    for (int i = 1; i < 55; i++) cyc(1, 0, 0, 0, (i % 3) == 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 1, 0);
    // Manual select beyond the 10-channel instance.
    cyc(1, 1, 0, 12, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 0);
    // Reset in the middle of a scan, then a fresh scan.
    cyc(1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 1, 0);
    // Random traffic with occasional resets.
    for (int i = 0; i < 2500; i++)
      cyc(($urandom % 150) != 0, ($urandom % 3) == 0, 1'($urandom % 2),
          int'($urandom % 16), ($urandom % 4) != 0, 1);
    for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0, 1, 1);
    chk("drain", 0, q16.size(), 0);
    chk("drain", 1, q10.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
